masked_and_chain_pipe: RTL and testbench

//  Parametrised N-input, 2-share masked AND built as a pipelined chain of DOM-indep AND stages.

---
 rtl/masked_and_chain_pipe.sv | 143 ++++++++++++++
 tb/tb_masked_and_chain_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_and_chain_pipe.sv
// Pipelined 2-share masked AND of N_IN bits built from DOM-indep stages with valid tracking.
// Optional macro OUT_REFRESH_EN adds a re-randomising output register fed by i_r_ref.
module masked_and_chain_pipe #(
  parameter int N_IN = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [N_IN-1:0] i_x0,
  input  logic [N_IN-1:0] i_x1,
  input  logic [N_IN-2:0] i_r,
`ifdef OUT_REFRESH_EN
  input  logic            i_r_ref,
`endif
  output logic            o_valid,
  output logic            o_out0,
  output logic            o_out1,
  output logic            o_busy
);

  localparam int NS = N_IN - 1;

  if (N_IN < 2 || N_IN > 8) begin : g_bad_param
    $error("masked_and_chain_pipe: N_IN must be in 2..8");
  end

  logic [NS:1] stg_v;
  logic [NS:1] z0, z1;
  logic [NS:1] b0, b1;

  assign b0[1] = i_x0[1];
  assign b1[1] = i_x1[1];

  // Input j travels alongside its token so it meets stage j in the right cycle.
  for (genvar j = 2; j <= NS; j++) begin : g_align
    logic [j-1:1] s0, s1;

    always_ff @(posedge clk) begin
      if (rst) begin
        s0 <= '0;
        s1 <= '0;
      end else begin
        if (i_valid) begin
          s0[1] <= i_x0[j];
          s1[1] <= i_x1[j];
        end
        for (int m = 2; m < j; m++) begin
          if (stg_v[m-1]) begin
            s0[m] <= s0[m-1];
            s1[m] <= s1[m-1];
          end
        end
      end
    end

    assign b0[j] = s0[j-1];
    assign b1[j] = s1[j-1];
  end

  for (genvar k = 1; k <= NS; k++) begin : g_stage
    logic vin, a0, a1;
    logic v, d0, d1, c01, c10;

    if (k == 1) begin : g_first
      assign vin = i_valid;
      assign a0  = i_x0[0];
      assign a1  = i_x1[0];
    end else begin : g_chain
      assign vin = stg_v[k-1];
      assign a0  = z0[k-1];
      assign a1  = z1[k-1];
    end

    // Cross-share terms are refreshed before being registered; share recombination
    // only happens after the registers, so glitches cannot merge both shares.
    always_ff @(posedge clk) begin
      if (rst) begin
        v   <= 1'b0;
        d0  <= 1'b0;
        d1  <= 1'b0;
        c01 <= 1'b0;
        c10 <= 1'b0;
      end else begin
        v <= vin;
        if (vin) begin
          d0  <= a0 & b0[k];
          d1  <= a1 & b1[k];
          c01 <= (a0 & b1[k]) ^ i_r[k-1];
          c10 <= (a1 & b0[k]) ^ i_r[k-1];
        end
      end
    end

    assign stg_v[k] = v;
    assign z0[k]    = d0 ^ c01;
    assign z1[k]    = d1 ^ c10;
  end

  logic q_v, q0, q1;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_v <= 1'b0;
      q0  <= 1'b0;
      q1  <= 1'b0;
    end else begin
      q_v <= stg_v[NS];
      if (stg_v[NS]) begin
        q0 <= z0[NS];
        q1 <= z1[NS];
      end
    end
  end

`ifdef OUT_REFRESH_EN
  logic f_v, f0, f1;

  always_ff @(posedge clk) begin
    if (rst) begin
      f_v <= 1'b0;
      f0  <= 1'b0;
      f1  <= 1'b0;
    end else begin
      f_v <= q_v;
      if (q_v) begin
        f0 <= q0 ^ i_r_ref;
        f1 <= q1 ^ i_r_ref;
      end
    end
  end

  assign o_valid = f_v;
  assign o_out0  = f0;
  assign o_out1  = f1;
  assign o_busy  = (|stg_v) | q_v | f_v;
`else
  assign o_valid = q_v;
  assign o_out0  = q0;
  assign o_out1  = q1;
  assign o_busy  = (|stg_v) | q_v;
`endif

endmodule

// File: tb/tb_masked_and_chain_pipe.sv
// Self-checking bench for masked_and_chain_pipe: directed scenarios on N_IN=3 plus
// randomized scoreboard runs on N_IN=2, 3 and 8 instances.
module tb_masked_and_chain_pipe;

`ifdef OUT_REFRESH_EN
  localparam int REF = 1;
`else
  localparam int REF = 0;
`endif
  localparam int LAT3 = 3 + REF;
  localparam int LAT2 = 2 + REF;
  localparam int LAT8 = 8 + REF;

  typedef struct {
    int due;
    bit val;
  } tok_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       v3 = 1'b0, v2 = 1'b0, v8 = 1'b0;
  logic [2:0] x0_3 = '0, x1_3 = '0;
  logic [1:0] r3 = '0;
  logic [1:0] x0_2 = '0, x1_2 = '0;
  logic [0:0] r2 = '0;
  logic [7:0] x0_8 = '0, x1_8 = '0;
  logic [6:0] r8 = '0;
`ifdef OUT_REFRESH_EN
  logic       rref = 1'b0;
`endif
  logic ov3, o03, o13, ob3;
  logic ov2, o02, o12, ob2;
  logic ov8, o08, o18, ob8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  masked_and_chain_pipe #(.N_IN(3)) dut3 (
    .clk(clk), .rst(rst), .i_valid(v3), .i_x0(x0_3), .i_x1(x1_3), .i_r(r3),
`ifdef OUT_REFRESH_EN
    .i_r_ref(rref),
`endif
    .o_valid(ov3), .o_out0(o03), .o_out1(o13), .o_busy(ob3)
  );

  masked_and_chain_pipe #(.N_IN(2)) dut2 (
    .clk(clk), .rst(rst), .i_valid(v2), .i_x0(x0_2), .i_x1(x1_2), .i_r(r2),
`ifdef OUT_REFRESH_EN
    .i_r_ref(rref),
`endif
    .o_valid(ov2), .o_out0(o02), .o_out1(o12), .o_busy(ob2)
  );

  masked_and_chain_pipe #(.N_IN(8)) dut8 (
    .clk(clk), .rst(rst), .i_valid(v8), .i_x0(x0_8), .i_x1(x1_8), .i_r(r8),
`ifdef OUT_REFRESH_EN
    .i_r_ref(rref),
`endif
    .o_valid(ov8), .o_out0(o08), .o_out1(o18), .o_busy(ob8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input logic v, input logic [2:0] u);
    logic [2:0] m;
    m    = 3'($urandom);
    v3   = v;
    x0_3 = m;
    x1_3 = m ^ u;
    r3   = 2'($urandom);
`ifdef OUT_REFRESH_EN
    rref = 1'($urandom);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v2 = 1'b1; v8 = 1'b1;
    drive3(1'b1, 3'b111);
    tick();
    tick();
    checks++;
    if ({ov3, o03, o13, ob3} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_n3: got %b expected 0000", {ov3, o03, o13, ob3});
    end
    checks++;
    if ({ov2, o02, o12, ob2} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_n2: got %b expected 0000", {ov2, o02, o12, ob2});
    end
    checks++;
    if ({ov8, o08, o18, ob8} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_n8: got %b expected 0000", {ov8, o08, o18, ob8});
    end
    rst = 1'b0;
    v2 = 1'b0; v8 = 1'b0;
    drive3(1'b0, 3'b000);
  endtask

  task automatic test_all_ones();
    v3 = 1'b1; x0_3 = 3'b101; x1_3 = 3'b010; r3 = 2'($urandom);
    tick();
    drive3(1'b0, 3'b000);
    for (int c = 1; c <= LAT3; c++) begin
      checks++;
      if (ov3 !== (c == LAT3)) begin
        errors++;
        $display("[TB] FAIL ones_valid c=%0d: got %b expected %b", c, ov3, c == LAT3);
      end
      checks++;
      if (ob3 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL ones_busy c=%0d: got %b expected 1", c, ob3);
      end
      if (c == LAT3) begin
        checks++;
        if ((o03 ^ o13) !== 1'b1) begin
          errors++;
          $display("[TB] FAIL ones_value: got %b expected 1", o03 ^ o13);
        end
      end else begin
        tick();
      end
    end
    tick();
    checks++;
    if ({ov3, ob3} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL ones_drain: got valid,busy=%b expected 00", {ov3, ob3});
    end
  endtask

  task automatic test_zeros_and_splits();
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin
        v3 = 1'b1; x0_3 = 3'b110; x1_3 = 3'b110; r3 = 2'($urandom);
      end else begin
        drive3(1'b1, 3'b111);
      end
      tick();
      drive3(1'b0, 3'b000);
      repeat (LAT3 - 1) tick();
      checks++;
      if (ov3 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL split_valid i=%0d: got %b expected 1", i, ov3);
      end
      checks++;
      if ((o03 ^ o13) !== (i != 0)) begin
        errors++;
        $display("[TB] FAIL split_value i=%0d: got %b expected %b", i, o03 ^ o13, i != 0);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c <= LAT3 + 8; c++) begin
      if (c > 0) begin
        checks++;
        if (ob3 !== (c <= LAT3 + 7)) begin
          errors++;
          $display("[TB] FAIL b2b_busy c=%0d: got %b expected %b", c, ob3, c <= LAT3 + 7);
        end
        checks++;
        if (ov3 !== (c >= LAT3 && c <= LAT3 + 7)) begin
          errors++;
          $display("[TB] FAIL b2b_valid c=%0d: got %b expected %b", c, ov3,
                   c >= LAT3 && c <= LAT3 + 7);
        end
        if (c >= LAT3 && c <= LAT3 + 7) begin
          checks++;
          if ((o03 ^ o13) !== (c - LAT3 == 7)) begin
            errors++;
            $display("[TB] FAIL b2b_value tok=%0d: got %b expected %b", c - LAT3,
                     o03 ^ o13, c - LAT3 == 7);
          end
        end
      end
      drive3(c < 8, 3'(c));
      tick();
    end
    drive3(1'b0, 3'b000);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive3(1'b1, 3'b111);
      tick();
    end
    rst = 1'b1;
    drive3(1'b1, 3'b111);
    tick();
    rst = 1'b0;
    drive3(1'b0, 3'b000);
    checks++;
    if ({ov3, o03, o13, ob3} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midrst_clear: got %b expected 0000", {ov3, o03, o13, ob3});
    end
    for (int c = 0; c < LAT3 + 3; c++) begin
      tick();
      checks++;
      if ({ov3, ob3} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL midrst_stale c=%0d: got valid,busy=%b expected 00", c, {ov3, ob3});
      end
    end
  endtask

  // With all stage randomness at zero each share reduces to x_s[0] AND the
  // unmasked higher inputs; the refresh stage (if built) inverts both shares.
  task automatic test_share_values();
    logic [2:0] u, m;
    logic e0, e1;
    for (int i = 0; i < 4; i++) begin
      u = 3'($urandom) | 3'b001;
      m = 3'($urandom);
      v3 = 1'b1; x0_3 = m; x1_3 = m ^ u; r3 = 2'b00;
`ifdef OUT_REFRESH_EN
      rref = 1'b1;
`endif
      e0 = (m[0] & u[1] & u[2]) ^ 1'(REF);
      e1 = ((m[0] ^ u[0]) & u[1] & u[2]) ^ 1'(REF);
      tick();
      v3 = 1'b0;
      repeat (LAT3 - 1) tick();
      checks++;
      if ({ov3, o03, o13} !== {1'b1, e0, e1}) begin
        errors++;
        $display("[TB] FAIL shares i=%0d: got valid,s0,s1=%b expected %b", i,
                 {ov3, o03, o13}, {1'b1, e0, e1});
      end
      tick();
    end
    drive3(1'b0, 3'b000);
  endtask

  task automatic test_random();
    tok_t q2[$], q3[$], q8[$];
    tok_t t;
    bit last2, last3, last8;
    int n2, n3, n8;
    logic [7:0] u8, m8;
    logic [2:0] u3, m3;
    logic [1:0] u2, m2;
    last2 = 0; last3 = 0; last8 = 0;
    n2 = 0; n3 = 0; n8 = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) begin
        checks++;
        if (ov2 !== (q2.size() > 0 && q2[0].due == cyc)) begin
          errors++;
          $display("[TB] FAIL rnd2_valid cyc=%0d: got %b", cyc, ov2);
        end else if (ov2) begin
          t = q2.pop_front();
          last2 = t.val;
        end
        checks++;
        if ((o02 ^ o12) !== last2) begin
          errors++;
          $display("[TB] FAIL rnd2_value cyc=%0d: got %b expected %b", cyc, o02 ^ o12, last2);
        end
        checks++;
        if (ov3 !== (q3.size() > 0 && q3[0].due == cyc)) begin
          errors++;
          $display("[TB] FAIL rnd3_valid cyc=%0d: got %b", cyc, ov3);
        end else if (ov3) begin
          t = q3.pop_front();
          last3 = t.val;
        end
        checks++;
        if ((o03 ^ o13) !== last3) begin
          errors++;
          $display("[TB] FAIL rnd3_value cyc=%0d: got %b expected %b", cyc, o03 ^ o13, last3);
        end
        checks++;
        if (ov8 !== (q8.size() > 0 && q8[0].due == cyc)) begin
          errors++;
          $display("[TB] FAIL rnd8_valid cyc=%0d: got %b", cyc, ov8);
        end else if (ov8) begin
          t = q8.pop_front();
          last8 = t.val;
        end
        checks++;
        if ((o08 ^ o18) !== last8) begin
          errors++;
          $display("[TB] FAIL rnd8_value cyc=%0d: got %b expected %b", cyc, o08 ^ o18, last8);
        end
      end
      u2 = ($urandom_range(3, 0) == 0) ? 2'b11 : 2'($urandom);
      u3 = ($urandom_range(3, 0) == 0) ? 3'b111 : 3'($urandom);
      u8 = ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom);
      m2 = 2'($urandom); m3 = 3'($urandom); m8 = 8'($urandom);
      v2 = (n2 < 1000) && ($urandom_range(2, 0) != 0);
      v3 = (n3 < 300) && ($urandom_range(2, 0) != 0);
      v8 = (n8 < 1000) && ($urandom_range(2, 0) != 0);
      x0_2 = m2; x1_2 = m2 ^ u2; r2 = 1'($urandom);
      x0_3 = m3; x1_3 = m3 ^ u3; r3 = 2'($urandom);
      x0_8 = m8; x1_8 = m8 ^ u8; r8 = 7'($urandom);
`ifdef OUT_REFRESH_EN
      rref = 1'($urandom);
`endif
      if (v2) begin q2.push_back('{cyc + LAT2, u2 == 2'b11}); n2++; end
      if (v3) begin q3.push_back('{cyc + LAT3, u3 == 3'b111}); n3++; end
      if (v8) begin q8.push_back('{cyc + LAT8, u8 == 8'hFF}); n8++; end
      tick();
    end
    checks++;
    if (q2.size() + q3.size() + q8.size() != 0 || n2 != 1000 || n8 != 1000) begin
      errors++;
      $display("[TB] FAIL rnd_drain: pending=%0d sent2=%0d sent8=%0d expected 0/1000/1000",
               q2.size() + q3.size() + q8.size(), n2, n8);
    end
    v2 = 1'b0; v3 = 1'b0; v8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_zeros_and_splits();
    test_back_to_back();
    test_reset_mid();
    test_share_values();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
